// File: rtl/xlr8_port_pkg.sv
// xlr8_port_pkg: shared constants, edge-select type and address-decode helper
// for the AVR GPIO port with pin-change interrupts (xlr8_avr_port_irq).
package xlr8_port_pkg;

    // Addresses at or above this value live on the data-memory bus.
    localparam logic [7:0] DM_BASE = 8'h60;

    // Width of each pin's glitch-filter stability counter.
    localparam int unsigned FILT_CNT_W = 4;

    // Edge selection encoding for drivers and benches.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2,
        ANY  = 2'd3
    } edge_sel_t;

    // A register is reached over the I/O bus below DM_BASE and over the
    // data-memory bus (qualified by dm_sel) at or above it.
    function automatic logic reg_hit(
        input logic [7:0] reg_addr,
        input logic [5:0] io_adr,
        input logic       io_stb,
        input logic [7:0] dm_adr,
        input logic       dm_sel,
        input logic       dm_stb
    );
        logic hit;
        if (reg_addr < DM_BASE) begin
            hit = io_stb && (io_adr == reg_addr[5:0]);
        end else begin
            hit = dm_sel && dm_stb && (dm_adr == reg_addr);
        end
        return hit;
    endfunction

endpackage

// File: rtl/xlr8_pin_filter.sv
// xlr8_pin_filter: glitch filter for one synchronized pin. The filtered value
// only follows the input after FILT_CYCLES consecutive clken cycles of
// disagreement; any agreeing cycle restarts the count.
module xlr8_pin_filter
    import xlr8_port_pkg::*;
#(
    parameter int unsigned FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic clken,
    input  logic sync_i,
    output logic filt_o
);

    localparam logic [FILT_CNT_W-1:0] CNT_ZERO = {FILT_CNT_W{1'b0}};
    localparam logic [FILT_CNT_W-1:0] CNT_ONE  = {{(FILT_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILT_CYCLES - 1);

    logic [FILT_CNT_W-1:0] cnt_q;
    logic [FILT_CNT_W-1:0] cnt_d;
    logic                  filt_q;
    logic                  filt_d;

    // Next-state: count disagreeing cycles, adopt the input on the last one.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (clken) begin
            if (sync_i == filt_q) begin
                cnt_d = CNT_ZERO;
            end else if (cnt_q >= CNT_LAST) begin
                cnt_d  = CNT_ZERO;
                filt_d = sync_i;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d  = cnt_q;
            filt_d = filt_q;
        end
    end

    // State registers; filtered value starts low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= CNT_ZERO;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/xlr8_avr_port_irq.sv
// xlr8_avr_port_irq: AVR GPIO port (PORTx/DDRx/PINx) with per-pin rising and
// falling pin-change interrupt enables and sticky write-1-to-clear flags.
// Optional build macro XLR8_PORT_GLITCH_FILTER_EN inserts a per-pin glitch
// filter (xlr8_pin_filter) between the synchronizer and the pin-value path.
module xlr8_avr_port_irq
    import xlr8_port_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter logic [7:0]  PORTX_ADDR    = 8'h00,
    parameter logic [7:0]  DDRX_ADDR     = 8'h00,
    parameter logic [7:0]  PINX_ADDR     = 8'h00,
    parameter logic [7:0]  PCRISE_ADDR   = 8'h00,
    parameter logic [7:0]  PCFALL_ADDR   = 8'h00,
    parameter logic [7:0]  PCFLG_ADDR    = 8'h00,
    parameter logic [7:0]  PORTX_RST_VAL = 8'h00,
    parameter logic [7:0]  DDRX_RST_VAL  = 8'h00,
    parameter int unsigned FILT_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clken,
    input  logic [5:0]       adr,
    input  logic             iore,
    input  logic             iowe,
    input  logic [7:0]       dbus_in,
    output logic [7:0]       dbus_out,
    output logic             io_out_en,
    input  logic [7:0]       ramadr,
    input  logic             ramre,
    input  logic             ramwe,
    input  logic             dm_sel,
    output logic [WIDTH-1:0] portx,
    output logic [WIDTH-1:0] ddrx,
    input  logic [WIDTH-1:0] pinx,
    output logic             pcifr_set,
    output logic             irq
);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    logic [WIDTH-1:0] sync_neg_q, sync_q, filt_s;
    logic [WIDTH-1:0] port_q, port_d, ddr_q, ddr_d;
    logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;
    logic [WIDTH-1:0] flg_q, flg_d, prev_q, prev_d;
    logic             prev_valid_q, prev_valid_d, pulse_q, pulse_d;
    logic [WIDTH-1:0] wr_val_s, clr_s, edge_s, rd_val_s;
    logic wr_port_s, wr_ddr_s, wr_pin_s, wr_rise_s, wr_fall_s, wr_flg_s;
    logic rd_port_s, rd_ddr_s, rd_pin_s, rd_rise_s, rd_fall_s, rd_flg_s;

    // Synchronizer first stage: free-running, captures pads on the falling edge.
    always_ff @(negedge clk) begin
        sync_neg_q <= pinx;
    end

    // Synchronizer second stage: free-running so pad state survives reset.
    always_ff @(posedge clk) begin
        sync_q <= sync_neg_q;
    end

`ifdef XLR8_PORT_GLITCH_FILTER_EN
    for (genvar g = 0; g < WIDTH; g++) begin : g_filt
        xlr8_pin_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt (
            .clk    (clk),
            .rstn   (rstn),
            .clken  (clken),
            .sync_i (sync_q[g]),
            .filt_o (filt_s[g])
        );
    end
`else
    assign filt_s = sync_q;
`endif

    assign wr_val_s  = dbus_in[WIDTH-1:0];
    assign wr_port_s = reg_hit(PORTX_ADDR,  adr, iowe, ramadr, dm_sel, ramwe);
    assign wr_ddr_s  = reg_hit(DDRX_ADDR,   adr, iowe, ramadr, dm_sel, ramwe);
    assign wr_pin_s  = reg_hit(PINX_ADDR,   adr, iowe, ramadr, dm_sel, ramwe);
    assign wr_rise_s = reg_hit(PCRISE_ADDR, adr, iowe, ramadr, dm_sel, ramwe);
    assign wr_fall_s = reg_hit(PCFALL_ADDR, adr, iowe, ramadr, dm_sel, ramwe);
    assign wr_flg_s  = reg_hit(PCFLG_ADDR,  adr, iowe, ramadr, dm_sel, ramwe);
    assign rd_port_s = reg_hit(PORTX_ADDR,  adr, iore, ramadr, dm_sel, ramre);
    assign rd_ddr_s  = reg_hit(DDRX_ADDR,   adr, iore, ramadr, dm_sel, ramre);
    assign rd_pin_s  = reg_hit(PINX_ADDR,   adr, iore, ramadr, dm_sel, ramre);
    assign rd_rise_s = reg_hit(PCRISE_ADDR, adr, iore, ramadr, dm_sel, ramre);
    assign rd_fall_s = reg_hit(PCFALL_ADDR, adr, iore, ramadr, dm_sel, ramre);
    assign rd_flg_s  = reg_hit(PCFLG_ADDR,  adr, iore, ramadr, dm_sel, ramre);

    // Edge detection, register writes and flag set/clear (set wins over clear).
    always_comb begin
        port_d       = port_q;
        ddr_d        = ddr_q;
        rise_d       = rise_q;
        fall_d       = fall_q;
        flg_d        = flg_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        clr_s        = ZERO_W;
        edge_s       = ZERO_W;
        if (clken) begin
            if (wr_port_s) begin
                port_d = wr_val_s;
            end else if (wr_pin_s) begin
                port_d = port_q ^ wr_val_s;
            end else begin
                port_d = port_q;
            end
            if (wr_ddr_s)  begin ddr_d  = wr_val_s; end else begin ddr_d  = ddr_q;  end
            if (wr_rise_s) begin rise_d = wr_val_s; end else begin rise_d = rise_q; end
            if (wr_fall_s) begin fall_d = wr_val_s; end else begin fall_d = fall_q; end
            if (wr_flg_s)  begin clr_s  = wr_val_s; end else begin clr_s  = ZERO_W; end
            if (prev_valid_q) begin
                edge_s = (filt_s & ~prev_q & rise_q) | (~filt_s & prev_q & fall_q);
            end else begin
                edge_s = ZERO_W;
            end
            flg_d        = (flg_q & ~clr_s) | edge_s;
            prev_d       = filt_s;
            prev_valid_d = 1'b1;
        end else begin
            edge_s = ZERO_W;
        end
        pulse_d = |edge_s;
    end

    // Port, enable, flag and edge-history registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            port_q       <= PORTX_RST_VAL[WIDTH-1:0];
            ddr_q        <= DDRX_RST_VAL[WIDTH-1:0];
            rise_q       <= ZERO_W;
            fall_q       <= ZERO_W;
            flg_q        <= ZERO_W;
            prev_q       <= ZERO_W;
            prev_valid_q <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            port_q       <= port_d;
            ddr_q        <= ddr_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            flg_q        <= flg_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            pulse_q      <= pulse_d;
        end
    end

    // Combinational read mux; bits above WIDTH read as zero.
    always_comb begin
        if (rd_port_s) begin
            rd_val_s = port_q;
        end else if (rd_ddr_s) begin
            rd_val_s = ddr_q;
        end else if (rd_pin_s) begin
            rd_val_s = filt_s;
        end else if (rd_rise_s) begin
            rd_val_s = rise_q;
        end else if (rd_fall_s) begin
            rd_val_s = fall_q;
        end else if (rd_flg_s) begin
            rd_val_s = flg_q;
        end else begin
            rd_val_s = ZERO_W;
        end
        dbus_out              = 8'h00;
        dbus_out[WIDTH-1:0]   = rd_val_s;
    end

    assign io_out_en = rd_port_s | rd_ddr_s | rd_pin_s | rd_rise_s | rd_fall_s | rd_flg_s;
    assign portx     = port_q;
    assign ddrx      = ddr_q;
    assign pcifr_set = pulse_q;
    assign irq       = |flg_q;

endmodule
